// File: rtl/hilo_div_pkg.sv
// Shared types and constants for the HI/LO divide unit.
package hilo_div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam logic [31:0] DIV0_QUOT = 32'hFFFFFFFF;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } divState_e;

endpackage

// File: rtl/hilo_div_unit_div_core.sv
// Unsigned restoring divider: one quotient bit per cycle, MSB first.
module div_core
  import hilo_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             last
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] aShift;
  logic [WIDTH-1:0] bReg;
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] rSub;

  // The full WIDTH+1 bit trial is compared; the difference always fits
  // back into WIDTH bits because the old remainder was below the divisor.
  assign trial = {r, aShift[WIDTH-1]};
  assign fits  = trial >= {1'b0, bReg};
  assign rSub  = trial[WIDTH-1:0] - bReg;
  assign last  = (cnt == CW'(1));

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt    <= '0;
      aShift <= '0;
      bReg   <= '0;
      q      <= '0;
      r      <= '0;
    end else if (load) begin
      cnt    <= CW'(WIDTH);
      aShift <= a;
      bReg   <= b;
      q      <= '0;
      r      <= '0;
    end else if (cnt != '0) begin
      cnt    <= cnt - CW'(1);
      aShift <= {aShift[WIDTH-2:0], 1'b0};
      q      <= {q[WIDTH-2:0], fits};
      r      <= fits ? rSub : trial[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/hilo_div_unit.sv
// DIV/DIVU front end: sign handling around div_core, HI/LO ownership and
// direct HI/LO writes, with busy for read interlock.
module hilo_div_unit
  import hilo_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             op_valid,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  divState_e        state;
  logic             signA;
  logic             signB;
  logic             bZero;
  logic [WIDTH-1:0] rawA;

  logic             accept;
  logic             negA;
  logic             negB;
  logic [WIDTH-1:0] magA;
  logic [WIDTH-1:0] magB;
  logic [WIDTH-1:0] coreQ;
  logic [WIDTH-1:0] coreR;
  logic             coreLast;

  assign accept = (state == IDLE) && op_valid;
  assign negA   = op_signed & op_a[WIDTH-1];
  assign negB   = op_signed & op_b[WIDTH-1];
  assign magA   = negA ? -op_a : op_a;
  assign magB   = negB ? -op_b : op_b;

  div_core #(.WIDTH(WIDTH)) uCore (
    .clock (clock),
    .reset (reset),
    .load  (accept),
    .a     (magA),
    .b     (magB),
    .q     (coreQ),
    .r     (coreR),
    .last  (coreLast)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      signA <= 1'b0;
      signB <= 1'b0;
      bZero <= 1'b0;
      rawA  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // A new op wins over same-cycle HI/LO writes.
          if (op_valid) begin
            signA <= negA;
            signB <= negB;
            bZero <= (op_b == '0);
            rawA  <= op_a;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            if (wr_hi) hi <= wr_data;
            if (wr_lo) lo <= wr_data;
          end
        end
        RUN: begin
          if (coreLast) state <= FIX;
        end
        FIX: begin
          if (bZero) begin
            lo <= WIDTH'(DIV0_QUOT);
            hi <= rawA;
          end else begin
            lo <= (signA ^ signB) ? -coreQ : coreQ;
            hi <= signA ? -coreR : coreR;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_div_unit.sv
// Self-checking bench: cycle-level arithmetic model of the unit, checked
// every cycle, plus directed literal cases and randomized traffic.
module tb_hilo_div_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        op_valid = 1'b0;
  logic        op_signed = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        wr_hi = 1'b0;
  logic        wr_lo = 1'b0;
  logic [31:0] wr_data = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int nChecks = 0;
  int nFail = 0;
  bit checkEn = 1'b0;

  hilo_div_unit #(.WIDTH(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .op_valid  (op_valid),
    .op_signed (op_signed),
    .op_a      (op_a),
    .op_b      (op_b),
    .wr_hi     (wr_hi),
    .wr_lo     (wr_lo),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected {hi, lo} straight from the arithmetic definition.
  function automatic logic [63:0] refDiv(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint na, nb, nq, nr;
    if (b == 32'd0) return {a, 32'hFFFFFFFF};
    if (s) begin
      na = longint'($signed(a));
      nb = longint'($signed(b));
    end else begin
      na = longint'({32'd0, a});
      nb = longint'({32'd0, b});
    end
    nq = na / nb;
    nr = na % nb;
    return {nr[31:0], nq[31:0]};
  endfunction

  // Cycle-level model: an op takes 33 edges, then the result appears.
  logic        mBusy = 1'b0;
  logic        mDone = 1'b0;
  logic [31:0] mHi = '0;
  logic [31:0] mLo = '0;
  logic [63:0] mPend = '0;
  int          mCnt = 0;

  always @(posedge clock) begin
    if (reset) begin
      mBusy = 1'b0; mDone = 1'b0; mHi = '0; mLo = '0; mCnt = 0;
    end else begin
      mDone = 1'b0;
      if (!mBusy) begin
        if (op_valid) begin
          mBusy = 1'b1;
          mCnt  = 33;
          mPend = refDiv(op_signed, op_a, op_b);
        end else begin
          if (wr_hi) mHi = wr_data;
          if (wr_lo) mLo = wr_data;
        end
      end else begin
        mCnt--;
        if (mCnt == 0) begin
          mBusy = 1'b0;
          mDone = 1'b1;
          mHi   = mPend[63:32];
          mLo   = mPend[31:0];
        end
      end
    end
  end

  always @(negedge clock) begin
    if (checkEn) begin
      check("busy", {31'd0, busy}, {31'd0, mBusy});
      check("done", {31'd0, done}, {31'd0, mDone});
      check("hi", hi, mHi);
      check("lo", lo, mLo);
    end
  end

  int busyCyc;
  bit gotDone;

  task automatic runOp(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    op_valid = 1'b1; op_signed = s; op_a = a; op_b = b;
    @(negedge clock);
    op_valid = 1'b0;
    busyCyc = 0;
    gotDone = 1'b0;
    for (int i = 0; i < 40 && !gotDone; i++) begin
      if (busy) busyCyc++;
      if (done) gotDone = 1'b1;
      else @(negedge clock);
    end
    check("op_done_seen", {31'd0, gotDone}, 32'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(1, 15));
      4: return -32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int doneSeen;
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    checkEn = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);

    // Unsigned 100 / 7.
    runOp(1'b0, 32'd100, 32'd7);
    check("u100_7_lo", lo, 32'd14);
    check("u100_7_hi", hi, 32'd2);
    check("u100_7_busycyc", 32'(busyCyc), 32'd33);
    @(negedge clock);
    check("u100_7_done_once", {31'd0, done}, 32'd0);

    // Signed -7 / 2.
    runOp(1'b1, 32'hFFFFFFF9, 32'd2);
    check("sm7_2_lo", lo, 32'hFFFFFFFD);
    check("sm7_2_hi", hi, 32'hFFFFFFFF);

    // Divide by zero, both signedness.
    runOp(1'b0, 32'd5, 32'd0);
    check("div0u_lo", lo, 32'hFFFFFFFF);
    check("div0u_hi", hi, 32'd5);
    runOp(1'b1, 32'd5, 32'd0);
    check("div0s_lo", lo, 32'hFFFFFFFF);
    check("div0s_hi", hi, 32'd5);

    // Signed overflow.
    runOp(1'b1, 32'h80000000, 32'hFFFFFFFF);
    check("ovf_lo", lo, 32'h80000000);
    check("ovf_hi", hi, 32'd0);

    // Conflicting op and write while busy are dropped.
    @(negedge clock);
    op_valid = 1'b1; op_signed = 1'b0; op_a = 32'd100; op_b = 32'd7;
    @(negedge clock);
    op_valid = 1'b0;
    repeat (9) @(negedge clock);
    op_valid = 1'b1; op_a = 32'd9; op_b = 32'd3; wr_lo = 1'b1; wr_data = 32'h1234;
    @(negedge clock);
    op_valid = 1'b0; wr_lo = 1'b0;
    gotDone = 1'b0;
    for (int i = 0; i < 40 && !gotDone; i++) begin
      if (done) gotDone = 1'b1;
      else @(negedge clock);
    end
    check("busy_conf_done", {31'd0, gotDone}, 32'd1);
    check("busy_conf_lo", lo, 32'd14);
    check("busy_conf_hi", hi, 32'd2);

    // Reset, direct write, then abort an op with reset.
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0; wr_hi = 1'b1; wr_data = 32'hAAAA;
    @(negedge clock);
    wr_hi = 1'b0;
    check("wrhi_hi", hi, 32'hAAAA);
    check("wrhi_nodone", {31'd0, done}, 32'd0);
    op_valid = 1'b1; op_a = 32'd1000; op_b = 32'd3;
    @(negedge clock);
    op_valid = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    doneSeen = 0;
    repeat (40) begin
      @(negedge clock);
      if (done) doneSeen++;
    end
    check("abort_nodone", 32'(doneSeen), 32'd0);

    // Randomized traffic, including back-to-back accepts and stray writes.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      reset     = ($urandom_range(0, 599) == 0);
      op_valid  = ($urandom_range(0, 5) == 0);
      op_signed = 1'($urandom_range(0, 1));
      op_a      = pick();
      op_b      = pick();
      wr_hi     = ($urandom_range(0, 7) == 0);
      wr_lo     = ($urandom_range(0, 7) == 0);
      wr_data   = $urandom;
    end
    @(negedge clock);
    reset = 1'b0; op_valid = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    repeat (40) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
